poly_collector: RTL and testbench

Receive-side endpoint for the coefficient stream a polynomial multiplier emits (`z_vld`/`z`/`z_last`, one coefficient per cycle, no backpressure honoured by the sender). The block gathers each N-coefficient frame into one of two ping-pong banks and presents complete polynomials as a single parallel word with a valid/ready handshake. It sits between the multiplier output and downstream FV-encryption stages that consume whole polynomials.

---
 rtl/poly_collector.sv | 112 +++++++++++
 tb/tb_poly_collector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/poly_collector.sv
// poly_collector: gathers N-coefficient frames from a multiplier stream into
// two ping-pong banks and presents whole polynomials with a valid/ready handshake.
// Ports: clk, s_rst_n (sync, active low); z_vld/z/z_last input beats (never stalled),
// z_rdy advisory free-bank flag; poly_vld/poly_rdy/poly parallel output
// (coefficient i at poly[i*QW +: QW]); len_err/ovf_err one-cycle error pulses.
// Build option: define POLY_COLLECTOR_LEN_CHECK_EN to discard short/long frames.
module poly_collector #(
    parameter int N  = 4,
    parameter int QW = 5
) (
    input  logic            clk,
    input  logic            s_rst_n,
    input  logic            z_vld,
    output logic            z_rdy,
    input  logic [QW-1:0]   z,
    input  logic            z_last,
    output logic            poly_vld,
    input  logic            poly_rdy,
    output logic [N*QW-1:0] poly,
    output logic            len_err,
    output logic            ovf_err
);
    localparam int LW = $clog2(N);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
`ifdef POLY_COLLECTOR_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic [1:0]      st;
    logic [LW-1:0]   wr_idx;
    logic            wr_bank;
    logic            rd_bank;
    logic [1:0]      full_cnt;
    logic            bad;
    logic            rdy_en;
    logic [N*QW-1:0] bank [2];

    logic          ovf;
    logic          wr_en;
    logic [LW-1:0] widx;
    logic          commit;
    logic          short_f;
    logic          long_f;
    logic          pop;

    always_comb begin
        ovf     = z_vld && st == S_IDLE && full_cnt == 2'd2;
        wr_en   = z_vld && !ovf && st != S_DROP;
        // the first beat of a frame always lands in slot 0
        widx    = st == S_IDLE ? '0 : wr_idx;
        commit  = wr_en && z_last && (!CHK || (st == S_RECV && wr_idx == LW'(N - 1)));
        short_f = wr_en && z_last && !commit;
        long_f  = CHK && wr_en && !z_last && st == S_RECV && wr_idx == LW'(N - 1);
        pop     = poly_vld && poly_rdy;
    end

    assign poly     = bank[rd_bank];
    assign poly_vld = full_cnt != 2'd0;
    // rdy_en holds z_rdy low through reset and raises it the cycle after release
    assign z_rdy    = rdy_en && full_cnt < 2'd2;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            st       <= S_IDLE;
            wr_idx   <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full_cnt <= 2'd0;
            bad      <= 1'b0;
            rdy_en   <= 1'b0;
            len_err  <= 1'b0;
            ovf_err  <= 1'b0;
            bank[0]  <= '0;
            bank[1]  <= '0;
        end else begin
            rdy_en   <= 1'b1;
            ovf_err  <= ovf;
            len_err  <= CHK && (short_f || (st == S_DROP && z_vld && z_last && bad));
            full_cnt <= full_cnt + {1'b0, commit} - {1'b0, pop};
            if (wr_en)
                bank[wr_bank][widx*QW +: QW] <= z;
            if (commit)
                wr_bank <= ~wr_bank;
            if (pop)
                rd_bank <= ~rd_bank;
            if (ovf) begin
                st  <= z_last ? S_IDLE : S_DROP;
                bad <= 1'b0;
            end else if (wr_en) begin
                if (z_last) begin
                    st     <= S_IDLE;
                    wr_idx <= '0;
                end else if (long_f) begin
                    st     <= S_DROP;
                    bad    <= 1'b1;
                    wr_idx <= '0;
                end else begin
                    // without length checking this wraps and overwrites earlier slots
                    st     <= S_RECV;
                    wr_idx <= widx + 1'b1;
                end
            end else if (st == S_DROP && z_vld && z_last) begin
                st  <= S_IDLE;
                bad <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_poly_collector.sv
// tb_poly_collector: directed scoreboard bench for poly_collector (N=4, QW=5).
module tb_poly_collector;
    logic        clk = 1'b0;
    logic        s_rst_n;
    logic        z_vld;
    logic        z_rdy;
    logic [4:0]  z;
    logic        z_last;
    logic        poly_vld;
    logic        poly_rdy;
    logic [19:0] poly;
    logic        len_err;
    logic        ovf_err;

    int n_vec = 0;
    int n_err = 0;
    int len_cnt = 0;
    int ovf_cnt = 0;
    logic [19:0] exp_q [$];

`ifdef POLY_COLLECTOR_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    poly_collector #(.N(4), .QW(5)) dut (
        .clk(clk), .s_rst_n(s_rst_n), .z_vld(z_vld), .z_rdy(z_rdy), .z(z),
        .z_last(z_last), .poly_vld(poly_vld), .poly_rdy(poly_rdy), .poly(poly),
        .len_err(len_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input int a, input int b, input int c, input int d);
        return {d[4:0], c[4:0], b[4:0], a[4:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input int v, input bit last);
        z_vld  = 1'b1;
        z      = v[4:0];
        z_last = last;
        cyc();
        z_vld  = 1'b0;
        z_last = 1'b0;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        beat(a, 0);
        beat(b, 0);
        beat(c, 0);
        beat(d, 1);
    endtask

    // inputs change 2 time units after posedge, so the negedge sees what the next edge samples
    always @(negedge clk) begin
        if (len_err === 1'b1) len_cnt++;
        if (ovf_err === 1'b1) ovf_cnt++;
        if (poly_vld === 1'b1 && poly_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL poly unexpected act=%h req=none", poly);
            end else begin
                chk("poly", {12'd0, poly}, {12'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        s_rst_n = 1'b0;
        z_vld = 1'b0;
        z = '0;
        z_last = 1'b0;
        poly_rdy = 1'b0;
        repeat (3) cyc();
        chk("rst_poly_vld", poly_vld, 0);
        chk("rst_poly", poly, 0);
        chk("rst_z_rdy", z_rdy, 0);
        chk("rst_errs", {len_err, ovf_err}, 0);
        s_rst_n = 1'b1;
        cyc();
        chk("z_rdy_after_rst", z_rdy, 1);

        // single frame, delivered one cycle after the last beat
        poly_rdy = 1'b1;
        exp_q.push_back(mk(3, 7, 31, 0));
        frame(3, 7, 31, 0);
        chk("single_vld", poly_vld, 1);
        chk("single_poly", poly, {5'd0, 5'd31, 5'd7, 5'd3});
        cyc();
        chk("single_vld_drop", poly_vld, 0);
        chk("single_no_err", len_cnt + ovf_cnt, 0);

        // overflow: A and B fill both banks, C is dropped
        poly_rdy = 1'b0;
        exp_q.push_back(mk(1, 2, 3, 4));
        exp_q.push_back(mk(5, 6, 7, 8));
        frame(1, 2, 3, 4);
        chk("ovf_z_rdy_one", z_rdy, 1);
        frame(5, 6, 7, 8);
        chk("ovf_z_rdy_full", z_rdy, 0);
        beat(9, 0);
        chk("ovf_pulse", ovf_err, 1);
        beat(10, 0);
        chk("ovf_pulse_once", ovf_err, 0);
        beat(11, 0);
        beat(12, 1);
        chk("ovf_hold_poly", poly, mk(1, 2, 3, 4));
        poly_rdy = 1'b1;
        cyc();
        cyc();
        chk("ovf_drained", poly_vld, 0);
        chk("ovf_count", ovf_cnt, 1);

        // short frame
        beat(9, 0);
        beat(9, 0);
        if (CHK) begin
            beat(9, 1);
            chk("short_len_err", len_err, 1);
            chk("short_no_vld", poly_vld, 0);
        end else begin
            exp_q.push_back(mk(9, 9, 9, 4));
            beat(9, 1);
            chk("short_len_err", len_err, 0);
            chk("short_commit", poly_vld, 1);
        end
        cyc();

        // long frame, then a good one
        if (!CHK) exp_q.push_back(mk(24, 25, 22, 23));
        for (int i = 20; i < 25; i++) beat(i, 0);
        beat(25, 1);
        chk("long_len_err", len_err, CHK);
        exp_q.push_back(mk(1, 1, 1, 1));
        frame(1, 1, 1, 1);
        chk("long_len_once", len_err, 0);
        cyc();
        chk("len_count", len_cnt, CHK ? 2 : 0);

        // commit and pop in the same cycle
        poly_rdy = 1'b0;
        exp_q.push_back(mk(2, 4, 6, 8));
        exp_q.push_back(mk(3, 5, 7, 9));
        frame(2, 4, 6, 8);
        beat(3, 0);
        beat(5, 0);
        beat(7, 0);
        poly_rdy = 1'b1;
        beat(9, 1);
        chk("sim_vld", poly_vld, 1);
        chk("sim_poly", poly, mk(3, 5, 7, 9));
        chk("sim_z_rdy", z_rdy, 1);
        cyc();
        chk("sim_drained", poly_vld, 0);

        // reset mid-frame with a bank full
        poly_rdy = 1'b0;
        frame(11, 12, 13, 14);
        beat(1, 0);
        beat(2, 0);
        s_rst_n = 1'b0;
        cyc();
        chk("mid_rst_outs", {poly_vld, z_rdy, len_err, ovf_err}, 0);
        chk("mid_rst_poly", poly, 0);
        s_rst_n = 1'b1;
        cyc();
        chk("post_rst_vld", poly_vld, 0);
        poly_rdy = 1'b1;
        exp_q.push_back(mk(30, 29, 28, 27));
        frame(30, 29, 28, 27);
        repeat (3) cyc();
        chk("queue_left", exp_q.size(), 0);
        chk("ovf_total", ovf_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
